xled_ctrl: RTL and testbench

Memory-mapped LED controller peripheral for picoVersat. It sits on the processor's peripheral bus next to the register file and drives the top-level `led` pin. Software writes a mode, period, duty and pulse count. The block then sequences the pin on its own: off, steady on, continuous blink, or a counted burst of N blinks with a completion strobe.

---
 rtl/xled_ctrl_pkg.sv | 28 ++
 rtl/xled_ctrl_if.sv | 13 +
 rtl/xled_timer.sv | 59 +++++
 rtl/xled_ctrl.sv | 132 +++++++++++++
 tb/tb_xled_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/xled_ctrl_pkg.sv
// Shared constants and types for the xled_ctrl LED controller: register map,
// mode encodings, FSM state encodings and the position of the busy flag.
package xled_ctrl_pkg;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPeriod = 2'd1;
  localparam logic [1:0] AddrDuty   = 2'd2;
  localparam logic [1:0] AddrCount  = 2'd3;

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModePulse = 2'd3
  } mode_t;

  typedef struct packed {
    logic  inv;
    mode_t mode;
  } ctrl_t;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSteady = 2'd1;
  localparam logic [1:0] StRun    = 2'd2;

  localparam int unsigned BusyBit = 31;

endpackage

// File: rtl/xled_ctrl_if.sv
// Peripheral bus between picoVersat and the LED controller.
interface xled_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              sel;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, output we, output addr, output data_in, input data_out);
  modport slave  (input sel, input we, input addr, input data_in, output data_out);
endinterface

// File: rtl/xled_timer.sv
// Period/duty timer: free-running counter with shadowed period and duty that
// only change on restart or at a period boundary.
module xled_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             run,
  input  logic             reload,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             boundary,
  output logic             on_phase
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] dty_q, dty_d;
  logic [CNT_W-1:0] period_eff;

  // A zero period behaves as a one-cycle period.
  assign period_eff = (period == '0) ? CNT_W'(1) : period;
  assign boundary   = run && (cnt_q == per_q - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    dty_d = dty_q;
    if (restart) begin
      cnt_d = '0;
      per_d = period_eff;
      dty_d = duty;
    end else if (run) begin
      cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
      if (reload) begin
        per_d = period_eff;
        dty_d = duty;
      end
    end
  end

  // Phase of the value the counter takes on the coming edge, so the
  // registered led lines up with the counter.
  assign on_phase = (cnt_d < dty_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      per_q <= '0;
      dty_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
      dty_q <= dty_d;
    end
  end

endmodule

// File: rtl/xled_ctrl.sv
// Memory-mapped LED controller: bus registers, OFF/ON/BLINK/PULSE sequencing
// FSM, burst counter and the registered led/done outputs.
module xled_ctrl
  import xled_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  xled_ctrl_if.slave  bus,
  output logic        led,
  output logic        done
);

  ctrl_t            ctrl_q, ctrl_d, wr_ctrl;
  logic [CNT_W-1:0] period_q, duty_q, count_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       state_q, state_d;
  logic             led_d, done_d;
  logic             wr, ctrl_wr, restart, boundary, on_phase, pulse_idle;
  logic             unused_data;

  assign wr          = bus.sel & bus.we;
  assign ctrl_wr     = wr && (bus.addr == AddrCtrl);
  assign wr_ctrl     = ctrl_t'(bus.data_in[2:0]);
  assign ctrl_d      = ctrl_wr ? wr_ctrl : ctrl_q;
  assign unused_data = ^bus.data_in[DATA_W-1:CNT_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      count_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      if (wr && (bus.addr == AddrPeriod)) period_q <= bus.data_in[CNT_W-1:0];
      if (wr && (bus.addr == AddrDuty))   duty_q   <= bus.data_in[CNT_W-1:0];
      if (wr && (bus.addr == AddrCount))  count_q  <= bus.data_in[CNT_W-1:0];
    end
  end

  xled_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .run      (state_q == StRun),
    .reload   (boundary),
    .period   (period_q),
    .duty     (duty_q),
    .boundary (boundary),
    .on_phase (on_phase)
  );

  // A CTRL write overrides any boundary or completion in the same cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    restart = 1'b0;
    if (ctrl_wr) begin
      case (wr_ctrl.mode)
        ModeOff:   state_d = StIdle;
        ModeOn:    state_d = StSteady;
        ModeBlink: begin
          state_d = StRun;
          restart = 1'b1;
        end
        default: begin
          state_d = StRun;
          restart = 1'b1;
          rem_d   = count_q;
        end
      endcase
    end else if ((state_q == StRun) && (ctrl_q.mode == ModePulse)) begin
      if (rem_q == '0) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else if (boundary) begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    end
  end

  // An empty burst never lights the led before it completes.
  assign pulse_idle = (ctrl_d.mode == ModePulse) && (rem_d == '0);

  always_comb begin
    case (state_d)
      StRun:    led_d = pulse_idle ? ctrl_d.inv : (on_phase ^ ctrl_d.inv);
      StSteady: led_d = ~ctrl_d.inv;
      default:  led_d = ctrl_d.inv;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      led     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      led     <= led_d;
      done    <= done_d;
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (bus.sel && !bus.we) begin
      case (bus.addr)
        AddrCtrl: begin
          bus.data_out[2:0]    = ctrl_q;
          bus.data_out[BusyBit] = (state_q == StRun);
        end
        AddrPeriod: bus.data_out[CNT_W-1:0] = period_q;
        AddrDuty:   bus.data_out[CNT_W-1:0] = duty_q;
        default:    bus.data_out[CNT_W-1:0] = rem_q;
      endcase
    end
  end

endmodule

// File: tb/tb_xled_ctrl.sv
// Self-checking bench for xled_ctrl: closed-form model of blink/pulse timing,
// randomized trials plus directed boundary, period-change, INV and reset cases.
module tb_xled_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led, done;
  int   tests = 0;
  int   fails = 0;

  xled_ctrl_if #(.DATA_W(32)) bus ();

  xled_ctrl #(
    .DATA_W (32),
    .CNT_W  (24)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .led  (led),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.sel     = 1'b1;
    bus.we      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    tick();
    bus.sel     = 1'b0;
    bus.we      = 1'b0;
    bus.data_in = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
  endtask

  // Model: k cycles after the CTRL write edge, led = ((k mod P) < D) ^ INV
  // while sequencing; a burst of N ends at k = N*P (k = 1 for N = 0).
  function automatic int eff_period(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic int done_at(input int p, input int n);
    return (n == 0) ? 1 : n * eff_period(p);
  endfunction

  function automatic logic model_led(input int k, input int mode, input int inv,
                                     input int p, input int d, input int n);
    int pe;
    pe = eff_period(p);
    if (mode == 3 && (n == 0 || k >= done_at(p, n))) return inv[0];
    return ((k % pe) < d) ^ inv[0];
  endfunction

  function automatic int model_rem(input int k, input int p, input int n);
    if (n == 0 || k >= done_at(p, n)) return 0;
    return n - k / eff_period(p);
  endfunction

  task automatic run_trial(input int mode, input int inv, input int p, input int d,
                           input int n);
    int            len, dk;
    logic [31:0]   ctrl_val, exp_rd;
    logic          busy;
    dk       = done_at(p, n);
    len      = (mode == 3) ? dk + 3 : 3 * eff_period(p) + 2;
    ctrl_val = 32'(inv * 4 + mode);
    bus_write(AddrSel0(), 32'd0);
    bus_write(2'd1, 32'(p));
    bus_write(2'd2, 32'(d));
    bus_write(2'd3, 32'(n));
    bus_write(2'd0, ctrl_val);
    for (int k = 0; k < len; k++) begin
      if (k > 0) tick();
      check($sformatf("led m%0d i%0d p%0d d%0d n%0d k%0d", mode, inv, p, d, n, k),
            32'(led), 32'(model_led(k, mode, inv, p, d, n)));
      check($sformatf("done m%0d p%0d n%0d k%0d", mode, p, n, k),
            32'(done), 32'((mode == 3) && (k == dk)));
      if (mode == 3 && (k % 2 == 0)) begin
        bus_read(2'd3);
        check($sformatf("rem p%0d n%0d k%0d", p, n, k), bus.data_out,
              32'(model_rem(k, p, n)));
      end else begin
        bus_read(2'd0);
        busy   = (mode == 2) || (k < dk);
        exp_rd = ctrl_val | (32'(busy) << 31);
        check($sformatf("ctrl rd m%0d k%0d", mode, k), bus.data_out, exp_rd);
      end
    end
    bus_read(2'd1);
    check("period rd", bus.data_out, 32'(p));
    bus_read(2'd2);
    check("duty rd", bus.data_out, 32'(d));
    bus.sel = 1'b0;
  endtask

  function automatic logic [1:0] AddrSel0();
    return 2'd0;
  endfunction

  initial begin
    logic [13:0] pc_tab;
    bus.sel     = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 2'd0;
    bus.data_in = '0;

    // Reset state
    #2;
    check("rst led", 32'(led), 32'd0);
    check("rst done", 32'(done), 32'd0);
    #10 rst = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a));
      check($sformatf("rst reg%0d", a), bus.data_out, 32'd0);
    end
    bus.sel = 1'b0;

    // Test-plan cases
    run_trial(2, 0, 4, 2, 0);
    run_trial(3, 0, 3, 1, 3);
    run_trial(2, 0, 4, 0, 0);
    run_trial(2, 0, 4, 5, 0);
    run_trial(2, 0, 0, 1, 0);
    run_trial(3, 0, 4, 2, 0);
    run_trial(3, 1, 2, 1, 2);

    // Randomized trials
    for (int t = 0; t < 16; t++) begin
      run_trial(2 + int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                int'($urandom_range(7, 0)), int'($urandom_range(9, 0)),
                int'($urandom_range(4, 0)));
    end

    // PERIOD change mid-period only takes effect at the next boundary
    pc_tab = 14'b00110000110011;
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'd2);
    check("pchg led k0", 32'(led), 32'(pc_tab[0]));
    for (int k = 1; k < 14; k++) begin
      if (k == 2) bus_write(2'd1, 32'd6);
      else tick();
      check($sformatf("pchg led k%0d", k), 32'(led), 32'(pc_tab[k]));
    end

    // Inverted blink, then steady-on mid-run
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      check($sformatf("inv led k%0d", k), 32'(led), 32'(k % 2));
    end
    bus_write(2'd0, 32'd1);
    check("steady led", 32'(led), 32'd1);
    bus_read(2'd0);
    check("steady ctrl rd", bus.data_out, 32'd1);
    bus.sel = 1'b0;
    tick();
    check("steady led hold", 32'(led), 32'd1);

    // Asynchronous reset in the middle of a burst
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd3);
    bus_write(2'd3, 32'd5);
    bus_write(2'd0, 32'd3);
    check("pre-rst led", 32'(led), 32'd1);
    for (int k = 0; k < 4; k++) tick();
    #2 rst = 1'b0;
    #1;
    check("async rst led", 32'(led), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    bus_read(2'd3);
    check("async rst rem rd", bus.data_out, 32'd0);
    bus.sel = 1'b0;
    tick();
    check("rst held led", 32'(led), 32'd0);
    #3 rst = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a));
      check($sformatf("post-rst reg%0d", a), bus.data_out, 32'd0);
    end
    bus.sel = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("post-rst done k%0d", k), 32'(done), 32'd0);
      check($sformatf("post-rst led k%0d", k), 32'(led), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
